img_frame_rx: RTL and testbench

IMG_FRAME_RX -- requirements
Module: img_frame_rx

---
 rtl/img_frame_rx.sv | 123 ++++++++++++
 tb/tb_img_frame_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_frame_rx.sv
// img_frame_rx: parses byte frames of the form
//   A5 | len[7:0] len[15:8] len[23:16] len[31:24] | payload x len | checksum
// and forwards payload bytes to a frame buffer one cycle after acceptance.
// The checksum is the 8-bit sum of the length and payload bytes; the sync
// byte is not included. Payload bytes are forwarded before the checksum is
// known, so o_err on a checksum mismatch is advisory only.
module img_frame_rx #(
  parameter int D_BITS  = 8,
  parameter int N       = 400,
  parameter int TIMEOUT = 100000
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [D_BITS-1:0] o_data,
  output logic              o_valid,
  output logic [31:0]       bleng,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;

  localparam logic [31:0] MAX_LEN  = 32'(N);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  localparam logic [7:0]  SYNC     = 8'hA5;

  state_t      state;
  logic [1:0]  len_cnt;
  logic [31:0] len_reg;
  logic [31:0] pay_cnt;
  logic [31:0] tmo_cnt;
  logic [7:0]  acc;

  // Full length as it will be once the current (4th) length byte lands.
  logic [31:0] len_full;
  logic [7:0]  acc_next;
  assign len_full = {rx_data, len_reg[23:0]};
  assign acc_next = acc + rx_data;

  // Busy whenever a frame is being parsed.
  assign o_busy = (state != HUNT);

  // Frame parser, idle timeout and registered output strobes.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state   <= HUNT;
      len_cnt <= 2'd0;
      len_reg <= 32'd0;
      pay_cnt <= 32'd0;
      tmo_cnt <= 32'd0;
      acc     <= 8'd0;
      o_data  <= '0;
      o_valid <= 1'b0;
      bleng   <= 32'd0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      if (rx_valid) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        tmo_cnt <= 32'd0;
        case (state)
          HUNT: begin
            if (rx_data == SYNC) begin
              state   <= LEN;
              len_cnt <= 2'd0;
              len_reg <= 32'd0;
              acc     <= 8'd0;
            end
          end
          LEN: begin
            len_reg[{len_cnt, 3'b000} +: 8] <= rx_data;
            acc     <= acc_next;
            len_cnt <= len_cnt + 2'd1;
            if (len_cnt == 2'd3) begin
              if (len_full == 32'd0 || len_full > MAX_LEN) begin
                // Bad header: bleng keeps the last good length.
                o_err <= 1'b1;
                state <= HUNT;
              end else begin
                bleng   <= len_full;
                pay_cnt <= 32'd0;
                state   <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            o_data  <= D_BITS'(rx_data);
            o_valid <= 1'b1;
            acc     <= acc_next;
            pay_cnt <= pay_cnt + 32'd1;
            if (pay_cnt == bleng - 32'd1) begin
              state <= CSUM;
            end
          end
          CSUM: begin
            if (rx_data == acc) begin
              o_done <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (state != HUNT) begin
        if (tmo_cnt == TMO_LAST) begin
          o_err   <= 1'b1;
          state   <= HUNT;
          tmo_cnt <= 32'd0;
        end else begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_img_frame_rx.sv
// Directed testbench for img_frame_rx: frames are driven byte by byte,
// a monitor logs forwarded payload and done/err pulses, and the main
// sequence compares against hand-computed expectations.
module tb_img_frame_rx;

  localparam int D_BITS  = 8;
  localparam int N       = 400;
  localparam int TIMEOUT = 20;

  logic              i_clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [D_BITS-1:0] o_data;
  logic              o_valid;
  logic [31:0]       bleng;
  logic              o_done;
  logic              o_err;
  logic              o_busy;

  int errors = 0;
  int checks = 0;

  // Monitor state
  logic [7:0]  got_q[$];
  logic [31:0] bl_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  // Snapshots taken before each scenario
  int base_q, base_done, base_err;

  img_frame_rx #(.D_BITS(D_BITS), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (i_clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .o_data  (o_data),
    .o_valid (o_valid),
    .bleng   (bleng),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Log every output strobe, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (reset) begin
      if (o_valid) begin
        got_q.push_back(o_data);
        bl_q.push_back(bleng);
      end
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
      if (o_done && o_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is accepted on the next posedge and the task
  // returns at the following negedge with rx_valid already low.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge i_clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic snap();
    base_q    = got_q.size();
    base_done = done_cnt;
    base_err  = err_cnt;
  endtask

  function automatic logic [7:0] got(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] bl_at(input int i);
    if (i < bl_q.size()) return bl_q[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic send_good_3();
    send(8'hA5); send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    send(8'h10); send(8'h20); send(8'h30); send(8'h63);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_bleng", bleng, 32'd0);
    check("rst_o_done", 32'(o_done), 32'd0);
    check("rst_o_err", 32'(o_err), 32'd0);
    check("rst_o_busy", 32'(o_busy), 32'd0);
    reset = 1'b1;
    idle(2);

    // Good frame A5 03 00 00 00 10 20 30 63
    snap();
    send(8'hA5);
    check("good_busy_after_sync", 32'(o_busy), 32'd1);
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    check("good_bleng_header", bleng, 32'd3);
    send(8'h10); send(8'h20); send(8'h30); send(8'h63);
    check("good_done_now", 32'(o_done), 32'd1);
    idle(3);
    check("good_nvalid", got_q.size() - base_q, 3);
    check("good_d0", 32'(got(base_q)), 32'h10);
    check("good_d1", 32'(got(base_q + 1)), 32'h20);
    check("good_d2", 32'(got(base_q + 2)), 32'h30);
    check("good_bleng_at_first_valid", bl_at(base_q), 32'd3);
    check("good_done_cnt", done_cnt - base_done, 1);
    check("good_err_cnt", err_cnt - base_err, 0);
    check("good_busy_end", 32'(o_busy), 32'd0);
    $display("txn good_frame: valid=%0d done=%0d err=%0d", got_q.size() - base_q, done_cnt - base_done, err_cnt - base_err);

    // Bad checksum 64
    snap();
    send(8'hA5); send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    send(8'h10); send(8'h20); send(8'h30); send(8'h64);
    check("badcs_err_now", 32'(o_err), 32'd1);
    idle(3);
    check("badcs_nvalid", got_q.size() - base_q, 3);
    check("badcs_d0", 32'(got(base_q)), 32'h10);
    check("badcs_d2", 32'(got(base_q + 2)), 32'h30);
    check("badcs_err_cnt", err_cnt - base_err, 1);
    check("badcs_done_cnt", done_cnt - base_done, 0);
    check("badcs_bleng", bleng, 32'd3);
    $display("txn bad_checksum: valid=%0d done=%0d err=%0d", got_q.size() - base_q, done_cnt - base_done, err_cnt - base_err);

    // Oversize length 401
    snap();
    send(8'hA5); send(8'h91); send(8'h01); send(8'h00); send(8'h00);
    check("big_err_now", 32'(o_err), 32'd1);
    check("big_busy", 32'(o_busy), 32'd0);
    idle(3);
    check("big_err_cnt", err_cnt - base_err, 1);
    check("big_nvalid", got_q.size() - base_q, 0);
    check("big_bleng_kept", bleng, 32'd3);
    $display("txn oversize_len: err=%0d bleng=%0d", err_cnt - base_err, bleng);

    // Zero length
    snap();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    check("zero_err_cnt", err_cnt - base_err, 1);
    check("zero_bleng_kept", bleng, 32'd3);
    $display("txn zero_len: err=%0d", err_cnt - base_err);

    // Timeout after header A5 02 00 00 00
    snap();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    check("tmo_bleng", bleng, 32'd2);
    idle(TIMEOUT - 1);
    check("tmo_busy_before", 32'(o_busy), 32'd1);
    check("tmo_err_before", err_cnt - base_err, 0);
    idle(1);
    check("tmo_err_pulse", 32'(o_err), 32'd1);
    check("tmo_busy_after", 32'(o_busy), 32'd0);
    idle(2);
    check("tmo_err_cnt", err_cnt - base_err, 1);
    snap();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h42); send(8'h43);
    idle(2);
    check("tmo_next_done", done_cnt - base_done, 1);
    check("tmo_next_data", 32'(got(base_q)), 32'h42);
    check("tmo_next_err", err_cnt - base_err, 0);
    $display("txn timeout_then_frame: done=%0d err=%0d", done_cnt - base_done, err_cnt - base_err);

    // Byte on the expiry cycle takes precedence over the timeout
    snap();
    send(8'hA5);
    idle(TIMEOUT - 1);
    send(8'h01);
    check("prec_busy", 32'(o_busy), 32'd1);
    check("prec_err_now", 32'(o_err), 32'd0);
    send(8'h00); send(8'h00); send(8'h00); send(8'h77); send(8'h78);
    idle(2);
    check("prec_err_cnt", err_cnt - base_err, 0);
    check("prec_done_cnt", done_cnt - base_done, 1);
    $display("txn timeout_precedence: done=%0d err=%0d", done_cnt - base_done, err_cnt - base_err);

    // Leading junk, A5 inside payload
    snap();
    send(8'h00); send(8'hFF);
    check("junk_busy", 32'(o_busy), 32'd0);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'hA5); send(8'hA6);
    idle(2);
    check("a5data_nvalid", got_q.size() - base_q, 1);
    check("a5data_d0", 32'(got(base_q)), 32'hA5);
    check("a5data_done", done_cnt - base_done, 1);
    check("a5data_bleng", bleng, 32'd1);
    $display("txn a5_as_data: valid=%0d data=%0h done=%0d", got_q.size() - base_q, got(base_q), done_cnt - base_done);

    // Reset in the middle of the payload
    snap();
    send(8'hA5); send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    send(8'h10);
    check("mid_valid_before", 32'(o_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_o_valid", 32'(o_valid), 32'd0);
    check("mid_rst_o_data", 32'(o_data), 32'd0);
    check("mid_rst_bleng", bleng, 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_err", 32'(o_err), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    check("mid_err_cnt", err_cnt - base_err, 0);
    snap();
    send_good_3();
    idle(2);
    check("mid_after_done", done_cnt - base_done, 1);
    check("mid_after_nvalid", got_q.size() - base_q, 3);
    check("mid_after_bleng", bleng, 32'd3);
    $display("txn reset_mid_frame: done=%0d err=%0d", done_cnt - base_done, err_cnt - base_err);

    check("never_done_and_err", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
